// File: rtl/des_pkg.sv
// Shared DES constants: PC-1/PC-2 tables, key shift schedule and key-schedule FSM states.
// Table entries are 1-based DES bit numbers (bit 1 = MSB of the source vector).
package des_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_ROUND = 5'd16;

    localparam logic [6:0] PC1_TBL [56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    localparam logic [5:0] PC2_TBL [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Encryption rotates left by this amount before round n; decryption undoes it after round n.
    function automatic logic [1:0] shift_amt(input logic [4:0] n);
        case (n)
            5'd1, 5'd2, 5'd9, 5'd16: shift_amt = 2'd1;
            default:                 shift_amt = 2'd2;
        endcase
    endfunction

    function automatic logic [1:56] pc1(input logic [1:64] k);
        for (int i = 0; i < 56; i++) begin
            pc1[i+1] = k[PC1_TBL[i]];
        end
    endfunction

endpackage

// File: rtl/des_dec_keysched_if.sv
// Subkey stream from the key scheduler to its consumer: valid/ready with round tag.
interface des_dec_keysched_if;
    logic [1:48] subkey_out;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [4:0]  round_num;

    modport master (output subkey_out, output subkey_valid, output round_num, input subkey_ready);
    modport slave  (input subkey_out, input subkey_valid, input round_num, output subkey_ready);
endinterface

// File: rtl/des_pc2.sv
// PC-2 compression of the 56-bit CD register into a 48-bit round subkey; purely combinational.
module des_pc2
    import des_pkg::*;
(
    input  logic [1:56] cd_i,
    output logic [1:48] subkey_o
);

    always_comb begin
        subkey_o = '0;
        for (int i = 0; i < 48; i++) begin
            subkey_o[i+1] = cd_i[PC2_TBL[i]];
        end
    end

endmodule

// File: rtl/des_dec_keysched.sv
// DES decryption key schedule: emits subkeys for rounds 16..1, first one cycle after start.
// Valid/ready output; subkey, round and CD hold for as long as ready stays low.
module des_dec_keysched
    import des_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:64]  key_in,
    output logic         busy,
    output logic         done,
    des_dec_keysched_if.master sk_if
);

    state_t      state_q, state_d;
    logic [1:56] cd_q, cd_d;
    logic [4:0]  round_q, round_d;
    logic [1:48] subkey;

    function automatic logic [1:28] rotr28(input logic [1:28] h, input logic [1:0] s);
        if (s == 2'd1) rotr28 = {h[28], h[1:27]};
        else           rotr28 = {h[27:28], h[1:26]};
    endfunction

    des_pc2 u_pc2 (
        .cd_i     (cd_q),
        .subkey_o (subkey)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cd_q    <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        round_d = round_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cd_d    = pc1(key_in);
                    round_d = LAST_ROUND;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (sk_if.subkey_ready) begin
                    if (round_q == 5'd1) begin
                        round_d = '0;
                        state_d = DONE;
                    end else begin
                        // Halves rotate independently; nothing crosses the C/D boundary.
                        cd_d    = {rotr28(cd_q[1:28], shift_amt(round_q)),
                                   rotr28(cd_q[29:56], shift_amt(round_q))};
                        round_d = round_q - 5'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign sk_if.subkey_out   = subkey;
    assign sk_if.subkey_valid = (state_q == EMIT);
    assign sk_if.round_num    = round_q;
    assign busy               = (state_q == EMIT);
    assign done               = (state_q == DONE);

endmodule

// File: tb/tb_des_dec_keysched.sv
// Scoreboard bench: forward key schedule model pushed in reverse, compared as subkeys are offered.
module tb_des_dec_keysched;

    typedef struct packed {
        logic [4:0]  rnd;
        logic [47:0] sk;
    } exp_t;

    localparam logic [1:64] GOLD_KEY = 64'h133457799BBCDFF1;

    localparam logic [6:0] T_PC1 [56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };
    localparam logic [5:0] T_PC2 [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:64] key_in;
    logic        busy;
    logic        done;

    des_dec_keysched_if sk_if ();

    des_dec_keysched dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .key_in (key_in),
        .busy   (busy),
        .done   (done),
        .sk_if  (sk_if)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:56] m_pc1(input logic [1:64] k);
        for (int i = 0; i < 56; i++) m_pc1[i+1] = k[T_PC1[i]];
    endfunction

    function automatic logic [47:0] m_pc2(input logic [1:56] cd);
        for (int i = 0; i < 48; i++) m_pc2[47-i] = cd[T_PC2[i]];
    endfunction

    function automatic logic [1:28] rol(input logic [1:28] h, input int s);
        rol = (h << s) | (h >> (28 - s));
    endfunction

    // Encryption schedule K1..K16 computed forward, then queued in decryption order.
    task automatic push_expected(input logic [1:64] k);
        logic [1:56] cd;
        logic [1:28] c, d;
        logic [47:0] ks [1:16];
        exp_t        e;
        int          s;
        cd = m_pc1(k);
        c  = cd[1:28];
        d  = cd[29:56];
        for (int r = 1; r <= 16; r++) begin
            s = (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
            c = rol(c, s);
            d = rol(d, s);
            ks[r] = m_pc2({c, d});
        end
        for (int r = 16; r >= 1; r--) begin
            e.rnd = 5'(r);
            e.sk  = ks[r];
            sb.push_back(e);
        end
    endtask

    task automatic begin_key(input logic [1:64] k);
        start  = 1'b1;
        key_in = k;
        push_expected(k);
        @(posedge clk); #1;
        start  = 1'b0;
        key_in = {$urandom, $urandom};
    endtask

    // mode 0: ready=1, 1: random ready, 2: 5-cycle stall at round 9,
    // 3: start pulse with alt_key mid-sequence, 4: reset at round 5.
    task automatic drain(input int mode, input logic [1:64] alt_key,
                         output logic [47:0] first_sk, output logic [47:0] last_sk);
        int   cyc   = 0;
        int   stall = 0;
        exp_t f;
        first_sk = '0;
        last_sk  = '0;
        while (sb.size() > 0 && cyc < 400) begin
            f      = sb[0];
            key_in = {$urandom, $urandom};
            start  = (mode == 3 && cyc == 3);
            if (mode == 3 && cyc == 3) key_in = alt_key;
            case (mode)
                1: sk_if.subkey_ready = ($urandom_range(3) != 0);
                2: begin
                    if (f.rnd == 5'd9 && stall < 5) begin
                        sk_if.subkey_ready = 1'b0;
                        stall++;
                    end else begin
                        sk_if.subkey_ready = 1'b1;
                    end
                end
                default: sk_if.subkey_ready = 1'b1;
            endcase
            if (mode == 4 && f.rnd == 5'd5) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                chk("rst_mid_valid", sk_if.subkey_valid, 0);
                chk("rst_mid_busy", busy, 0);
                chk("rst_mid_done", done, 0);
                chk("rst_mid_round", sk_if.round_num, 0);
                sb.delete();
                @(posedge clk); #1;
                chk("rst_mid_stays_idle", sk_if.subkey_valid, 0);
                return;
            end
            @(negedge clk);
            chk("valid", sk_if.subkey_valid, 1);
            chk("round", sk_if.round_num, f.rnd);
            chk("subkey", sk_if.subkey_out, f.sk);
            chk("busy", busy, 1);
            if (cyc == 0) first_sk = sk_if.subkey_out;
            last_sk = sk_if.subkey_out;
            if (sk_if.subkey_ready) void'(sb.pop_front());
            cyc++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("drained", (sb.size() == 0), 1);
        if (mode == 0) chk("stream_cycles", cyc, 16);
        if (mode == 2) chk("stall_cycles", stall, 5);
        sk_if.subkey_ready = 1'($urandom_range(1));
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_valid", sk_if.subkey_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_clear", done, 0);
        chk("idle_valid", sk_if.subkey_valid, 0);
        @(posedge clk); #1;
    endtask

    logic [47:0] fsk, lsk;

    initial begin
        rst                = 1'b1;
        start              = 1'b1;
        key_in             = GOLD_KEY;
        sk_if.subkey_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_valid", sk_if.subkey_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_round", sk_if.round_num, 0);
        chk("reset_subkey", sk_if.subkey_out, 0);
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;

        begin_key(GOLD_KEY);
        drain(0, '0, fsk, lsk);
        chk("gold_round16", fsk, 48'hCB3D8B0E17F5);
        chk("gold_round1", lsk, 48'h1B02EFFC7072);

        begin_key(GOLD_KEY);
        drain(2, '0, fsk, lsk);

        begin_key(GOLD_KEY);
        drain(3, 64'h0123456789ABCDEF, fsk, lsk);
        chk("ignored_start_last", lsk, 48'h1B02EFFC7072);

        begin_key({$urandom, $urandom});
        drain(4, '0, fsk, lsk);

        begin_key(GOLD_KEY);
        drain(0, '0, fsk, lsk);
        chk("restart_round16", fsk, 48'hCB3D8B0E17F5);

        for (int n = 0; n < 1000; n++) begin
            begin_key({$urandom, $urandom});
            drain(1, '0, fsk, lsk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/des_dec_keysched.md
DES_DEC_KEYSCHED -- requirements
Module: des_dec_keysched

Interface
REQ-001 The block SHALL expose `clk`, input, 1 bit: the single rising-edge clock.
REQ-002 The block SHALL expose `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL expose `start`, input, 1 bit: request to begin a decryption subkey sequence; sampled only in IDLE.
REQ-004 The block SHALL expose `key_in`, input, [1:64]: 64-bit DES key in DES bit numbering (bit 1 = MSB); parity bits ignored; sampled on the start-accept edge.
REQ-005 The block SHALL expose `subkey_out`, output, [1:48]: current round subkey in DES bit numbering.
REQ-006 The block SHALL expose `subkey_valid`, output, 1 bit: `subkey_out` holds a valid subkey.
REQ-007 The block SHALL expose `subkey_ready`, input, 1 bit: consumer accepts the subkey; a transfer occurs on an edge where valid and ready are both 1.
REQ-008 The block SHALL expose `round_num`, output, [4:0]: DES round index of `subkey_out`, from 16 down to 1.
REQ-009 The block SHALL expose `busy`, output, 1 bit: high from the start-accept edge until the final transfer completes.
REQ-010 The block SHALL expose `done`, output, 1 bit: one-cycle pulse in the cycle after the round-1 transfer.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, EMIT and DONE.
REQ-012 In IDLE with `start`=1, the next edge SHALL load CD <= PC-1(`key_in`) (56 bits: C = [1:28], D = [29:56]) and enter EMIT with `round_num`=16.
REQ-013 In EMIT, `subkey_out` SHALL equal PC-2(CD) and `subkey_valid` SHALL be 1; no extra latency cycle.
REQ-014 On a transfer in EMIT with `round_num`=n>1, C and D SHALL each rotate right by shift(n), and `round_num` SHALL become n-1.
REQ-015 The shift schedule SHALL be shift(n)=1 for n in {1,2,9,16} and shift(n)=2 otherwise.
REQ-016 Rotation SHALL stay within each 28-bit half; there SHALL be no carry between C and D.
REQ-017 On a transfer with `round_num`=1, the FSM SHALL enter DONE; DONE SHALL assert `done` for one cycle and then return to IDLE.
REQ-018 While `subkey_valid`=1 and `subkey_ready`=0, `subkey_out`, `round_num` and CD SHALL hold stable (back-pressure, unlimited stall).
REQ-019 `start` asserted outside IDLE SHALL be ignored; `key_in` changes outside the accept edge SHALL have no effect.
REQ-020 `busy` SHALL be 1 in EMIT and 0 in IDLE and DONE.
REQ-021 Start-accept to first valid SHALL take 1 cycle; with `subkey_ready` held at 1, the 16 subkeys SHALL take 16 consecutive cycles and `done` SHALL follow in cycle 17.
REQ-022 After 16 transfers the cumulative right rotation SHALL be 28, restoring CD to PC-1(key).

Reset
REQ-023 When `rst`=1 at an edge, the FSM SHALL enter IDLE, clear CD to 0, set `round_num` to 0, and drive `subkey_valid`, `busy` and `done` to 0.
REQ-024 Reset SHALL take priority over `start` and over any transfer, including mid-sequence; an aborted sequence SHALL not resume.

Structure
REQ-025 A shared package `des_pkg` SHALL hold the PC-1 and PC-2 tables, the shift schedule, and the FSM state enum; the S-box and encryption datapath SHALL reuse it.
REQ-026 One combinational sub-module, `des_pc2` (56 -> 48 bits), SHALL implement PC-2; PC-1 and the rotation SHALL be inline.

Verification
REQ-027 Key 0x133457799BBCDFF1, start, ready held 1 -> first subkey is round 16 = 0xCB3D8B0E17F5, one cycle after accept.
REQ-028 Same key -> the 16th subkey is round 1 = 0x1B02EFFC7072, followed by a `done` pulse in the next cycle.
REQ-029 Ready deasserted for 5 cycles at `round_num`=9 -> `subkey_out` and `round_num` hold for 5 cycles; the sequence then resumes with round 8 and matches the golden model.
REQ-030 `start` pulsed with a new key during EMIT -> it is ignored and all 16 subkeys match the original key.
REQ-031 `rst` asserted at `round_num`=5 -> next cycle is IDLE with valid, busy and done at 0; a new start then reproduces the full sequence from round 16.
REQ-032 Random keys (1000 keys), random ready -> the subkey stream equals the reversed encryption key schedule of a reference model.
